// File: rtl/sdram_bram_responder.sv
// Block-RAM stand-in for the SDRAM controller's user-side burst request/ack interface.
// Define SDRAM_RESP_REFRESH_EN to emulate periodic refresh windows that stall bursts.
module sdram_bram_responder #(
   parameter int ADDR_W         = 10,
   parameter int INIT_CYCLES    = 200,
   parameter int CAS_LAT        = 2,
   parameter int REFRESH_PERIOD = 780
) (
   input  logic        clk_50m,
   input  logic        rst_n,
   input  logic [23:0] sdram_wr_addr,
   input  logic [15:0] sdram_wr_data,
   input  logic        sdram_wr_req,
   input  logic [8:0]  sdwr_bytes,
   output logic        sdram_wr_ack,
   input  logic [23:0] sdram_rd_addr,
   output logic [15:0] sdram_rd_data,
   input  logic        sdram_rd_req,
   input  logic [8:0]  sdrd_bytes,
   output logic        sdram_rd_ack,
   output logic        sdram_init_done,
   output logic        sdram_busy
);

   localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
   localparam logic [7:0]  CAS_LAST  = 8'(CAS_LAT - 1);

`ifdef SDRAM_RESP_REFRESH_EN
   typedef enum logic [2:0] {INIT, IDLE, WR, RD_WAIT, RD_DATA, REF} state_t;
   localparam logic [15:0] REF_LAST = 16'(REFRESH_PERIOD - 1);
   logic [15:0] refCnt_q;
   logic        refPend_q;
`else
   typedef enum logic [2:0] {INIT, IDLE, WR, RD_WAIT, RD_DATA} state_t;
   localparam int unusedRefPeriod = REFRESH_PERIOD;
`endif

   state_t              state_q;
   logic [15:0]         initCnt_q;
   logic [7:0]          waitCnt_q;
   logic [8:0]          issued_q;
   logic [8:0]          len_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                wrPend_q, rdPend_q;
   logic [ADDR_W-1:0]   wrPendAddr_q, rdPendAddr_q;
   logic [8:0]          wrPendLen_q, rdPendLen_q;
   logic                wrReqPrev_q, rdReqPrev_q;
   logic                wrAck_q, rdAck_q, initDone_q, busy_q;
   logic [15:0]         rdData_q;
   logic                pendAny;
   logic                memWe;
   logic [15:0]         rdWord;
   logic [15:0]         mem [2**ADDR_W];
   logic                unusedAddrBits;

   assign unusedAddrBits = ^{sdram_wr_addr[23:ADDR_W], sdram_rd_addr[23:ADDR_W]};

`ifdef SDRAM_RESP_REFRESH_EN
   assign pendAny = wrPend_q | rdPend_q | refPend_q;
`else
   assign pendAny = wrPend_q | rdPend_q;
`endif

   // A write word is consumed on every edge where its ack is already showing.
   assign memWe  = (state_q == WR) && wrAck_q;
   assign rdWord = mem[addr_q];

   always_ff @(posedge clk_50m) begin
      if (memWe) mem[addr_q] <= sdram_wr_data;
   end

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= INIT;
         initCnt_q    <= '0;
         waitCnt_q    <= '0;
         issued_q     <= '0;
         len_q        <= '0;
         addr_q       <= '0;
         wrPend_q     <= 1'b0;
         rdPend_q     <= 1'b0;
         wrPendAddr_q <= '0;
         rdPendAddr_q <= '0;
         wrPendLen_q  <= '0;
         rdPendLen_q  <= '0;
         wrReqPrev_q  <= 1'b0;
         rdReqPrev_q  <= 1'b0;
         wrAck_q      <= 1'b0;
         rdAck_q      <= 1'b0;
         rdData_q     <= '0;
         initDone_q   <= 1'b0;
         busy_q       <= 1'b1;
`ifdef SDRAM_RESP_REFRESH_EN
         refCnt_q     <= '0;
         refPend_q    <= 1'b0;
`endif
      end else begin
         wrReqPrev_q <= sdram_wr_req;
         rdReqPrev_q <= sdram_rd_req;
         busy_q      <= !(state_q == IDLE && !pendAny);

         case (state_q)
            INIT: begin
               if (initCnt_q == INIT_LAST) begin
                  initDone_q <= 1'b1;
                  state_q    <= IDLE;
               end else begin
                  initCnt_q <= initCnt_q + 16'd1;
               end
            end
            IDLE: begin
`ifdef SDRAM_RESP_REFRESH_EN
               if (refPend_q) begin
                  refPend_q <= 1'b0;
                  waitCnt_q <= '0;
                  state_q   <= REF;
               end else
`endif
               if (wrPend_q) begin
                  wrPend_q <= 1'b0;
                  if (wrPendLen_q != 9'd0) begin
                     addr_q   <= wrPendAddr_q;
                     len_q    <= wrPendLen_q;
                     issued_q <= '0;
                     state_q  <= WR;
                  end
               end else if (rdPend_q) begin
                  rdPend_q <= 1'b0;
                  if (rdPendLen_q != 9'd0) begin
                     addr_q    <= rdPendAddr_q;
                     len_q     <= rdPendLen_q;
                     issued_q  <= '0;
                     waitCnt_q <= '0;
                     state_q   <= RD_WAIT;
                  end
               end
            end
            WR: begin
               if (wrAck_q) addr_q <= addr_q + ADDR_W'(1);
               if (issued_q != len_q) begin
                  wrAck_q  <= 1'b1;
                  issued_q <= issued_q + 9'd1;
               end else begin
                  wrAck_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RD_WAIT: begin
               if (waitCnt_q == CAS_LAST) state_q <= RD_DATA;
               else waitCnt_q <= waitCnt_q + 8'd1;
            end
            RD_DATA: begin
               if (issued_q != len_q) begin
                  rdAck_q  <= 1'b1;
                  rdData_q <= rdWord;
                  addr_q   <= addr_q + ADDR_W'(1);
                  issued_q <= issued_q + 9'd1;
               end else begin
                  rdAck_q <= 1'b0;
                  state_q <= IDLE;
               end
            end
`ifdef SDRAM_RESP_REFRESH_EN
            REF: begin
               if (waitCnt_q == 8'd7) state_q <= IDLE;
               else waitCnt_q <= waitCnt_q + 8'd1;
            end
`endif
            default: state_q <= INIT;
         endcase

         // Capture sits after dispatch so a fresh request on the dispatch edge survives.
         if (state_q != INIT && sdram_wr_req && !wrReqPrev_q) begin
            wrPend_q     <= 1'b1;
            wrPendAddr_q <= sdram_wr_addr[ADDR_W-1:0];
            wrPendLen_q  <= sdwr_bytes;
         end
         if (state_q != INIT && sdram_rd_req && !rdReqPrev_q) begin
            rdPend_q     <= 1'b1;
            rdPendAddr_q <= sdram_rd_addr[ADDR_W-1:0];
            rdPendLen_q  <= sdrd_bytes;
         end

`ifdef SDRAM_RESP_REFRESH_EN
         if (refCnt_q == REF_LAST) begin
            refCnt_q  <= '0;
            refPend_q <= 1'b1;
         end else begin
            refCnt_q <= refCnt_q + 16'd1;
         end
`endif
      end
   end

   assign sdram_wr_ack    = wrAck_q;
   assign sdram_rd_ack    = rdAck_q;
   assign sdram_rd_data   = rdData_q;
   assign sdram_init_done = initDone_q;
   assign sdram_busy      = busy_q;

endmodule

// File: doc/sdram_bram_responder.md
# sdram_bram_responder

Responder for the SDRAM controller's user-side request/ack interface: it accepts `sdram_wr_req` / `sdram_rd_req` bursts exactly as a requester drives them and services them from an on-chip block-RAM array instead of external SDRAM. The requester (counter, CPU bus bridge, test harness) can be swapped between this block and the real controller without change. Used for board bring-up without SDRAM and for fast simulation of requester logic.

## Interface
Parameters:
- `ADDR_W`, 10: word-address bits actually stored; depth = 2^ADDR_W 16-bit words
- `INIT_CYCLES`, 200: clocks after reset before `sdram_init_done` rises
- `CAS_LAT`, 2: idle clocks between read acceptance and first read data word
- `REFRESH_PERIOD`, 780: clocks between refresh windows (used only with `SDRAM_RESP_REFRESH_EN`)

Ports:
- `clk_50m`  in  1: single clock, all logic on rising edge
- `rst_n`  in  1: asynchronous, active-low reset
- `sdram_wr_addr`  in  24: write burst start word address
- `sdram_wr_data`  in  16: write data word
- `sdram_wr_req`  in  1: write request pulse (≥1 cycle)
- `sdwr_bytes`  in  9: write burst length in words
- `sdram_wr_ack`  out  1: high for each cycle a write word is consumed
- `sdram_rd_addr`  in  24: read burst start word address
- `sdram_rd_data`  out  16: read data word
- `sdram_rd_req`  in  1: read request pulse (≥1 cycle)
- `sdrd_bytes`  in  9: read burst length in words
- `sdram_rd_ack`  out  1: high for each cycle `sdram_rd_data` is valid
- `sdram_init_done`  out  1: initialisation complete, sticky until reset
- `sdram_busy`  out  1: high whenever not ready to start a burst this cycle

## Operation
- States: INIT, IDLE, WR, RD_WAIT, RD_DATA (+ REF with macro).
- INIT: counter runs to INIT_CYCLES-1, then `sdram_init_done`<=1, state IDLE. Requests during INIT are ignored (not latched).
- Request capture (after init): a rising-level `*_req` seen on any clock latches {addr, len} into a one-deep pending slot per direction. A second request of the same direction while its slot is full overwrites it (latest wins).
- IDLE: if write pending -> WR; else if read pending -> RD_WAIT. Write has priority on simultaneous pending. Pending slot cleared on dispatch.
- Length 0 is a no-op: slot cleared, no ack, remain IDLE.
- WR: for i = 0..len-1, one word per cycle: `sdram_wr_ack`=1, `sdram_wr_data` sampled on that edge, written to mem[(addr+i) mod 2^ADDR_W]. Then IDLE.
- RD_WAIT: CAS_LAT cycles, no ack. RD_DATA: len cycles, `sdram_rd_ack`=1, `sdram_rd_data`=mem[(addr+i) mod 2^ADDR_W]. Then IDLE.
- Address: only `addr[ADDR_W-1:0]` used; upper bits ignored; increment wraps within the array.
- `sdram_rd_data` holds the last word read after a burst ends.
- `sdram_busy` = 1 in every state except IDLE with no pending request.

## Timing
- Reset values: `sdram_wr_ack`=0, `sdram_rd_ack`=0, `sdram_rd_data`=0, `sdram_init_done`=0, `sdram_busy`=1; state INIT; pending slots empty. Memory contents not cleared.
- `sdram_init_done` rises exactly INIT_CYCLES clocks after `rst_n` deasserts.
- Write: req sampled at edge T (idle) -> first `sdram_wr_ack` in cycle T+2; len consecutive ack cycles.
- Read: req at edge T (idle) -> first `sdram_rd_ack` in cycle T+2+CAS_LAT; len consecutive ack cycles; data registered, valid same cycle as ack.
- Back-to-back: next pending burst starts one IDLE cycle after the previous burst's last ack.
- Reset mid-burst: burst abandoned immediately, acks low asynchronously, INIT restarts; words already written stay written.

## Configuration
- `SDRAM_RESP_REFRESH_EN` defined: free-running counter raises a refresh request every REFRESH_PERIOD clocks; taken from IDLE ahead of any pending burst; REF state lasts 8 cycles, busy=1, no acks. Requests arriving meanwhile are latched normally. Never interrupts a burst; a refresh due mid-burst waits for IDLE.
- Undefined: no REF state, no refresh counter; IDLE dispatches immediately.

## Test plan
- Reset, INIT_CYCLES=200 -> `sdram_init_done` rises on cycle 200, busy falls cycle 201; req pulsed at cycle 50 produces no ack.
- Write addr 0x000005 len 4 data 0xA001..0xA004, then read addr 0x000005 len 4 -> 4 wr_ack cycles, then 4 rd_ack cycles returning 0xA001..0xA004, first rd_ack at req+4.
- Write and read req on same edge -> write burst completes first, read data reflects new values.
- ADDR_W=10, write addr 0x0003FE len 4 -> words land at 0x3FE,0x3FF,0x000,0x001; read 0x000400 len 1 returns word at 0x000.
- Len 0 write -> no ack, busy low next cycle; rst_n low during 8-word read after 3 acks -> acks drop immediately, init_done=0, INIT restarts.
- With `SDRAM_RESP_REFRESH_EN`, REFRESH_PERIOD=780: req arriving at refresh point -> 8 busy cycles without ack, then burst served with normal latency.
